simon_data_out: RTL and testbench

Byte-serial result transmitter for the SIMON core, and the return path of the packet protocol that SIMON_dataIN decodes. It accepts one finished cipher block from the core and frames it into a host packet: info byte, count byte, block bytes, zero padding. It streams the packet MSB-byte-first over a valid/ready byte interface toward the host link. A one-entry holding register lets the core hand over the next result while the current packet is still streaming.

---
 rtl/simon_pkg.sv | 20 ++
 rtl/simon_pkt_shift.sv | 37 +++
 rtl/simon_data_out.sv | 126 ++++++++++++
 tb/tb_simon_data_out.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON result transmitter.
package simon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int INFO_VALID_BIT = 7;
    localparam int INFO_ENC_BIT   = 6;

    // One packet byte; a packet image is a packed array of these.
    typedef logic [7:0] byte_t;

    // Info byte + count byte + two N-bit words + zero padding.
    function automatic int pkt_bytes(input int n);
        return 2 + n / 2;
    endfunction

endpackage

// File: rtl/simon_pkt_shift.sv
// Packet image register: parallel load, shifts one byte toward the top per enable.
module simon_pkt_shift
    import simon_pkg::*;
#(
    parameter int PKT_BYTES = 10,
    localparam int IW = $clog2(PKT_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  byte_t [PKT_BYTES-1:0]   load_img,
    input  logic                    shift_en,
    output byte_t                   top_byte,
    output logic                    last
);

    byte_t [PKT_BYTES-1:0] img;
    logic  [IW-1:0]        idx;

    // Zeros shift in from the bottom, so the top byte idles at zero once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img <= '0;
            idx <= '0;
        end else if (load) begin
            img <= load_img;
            idx <= '0;
        end else if (shift_en) begin
            img <= {img[PKT_BYTES-2:0], 8'h00};
            idx <= idx + 1'b1;
        end
    end

    assign top_byte = img[PKT_BYTES-1];
    assign last     = (idx == IW'(PKT_BYTES - 1));

endmodule

// File: rtl/simon_data_out.sv
// Frames one SIMON result block per packet and streams it byte-serially to the host,
// with a one-entry holding register so the core can hand over the next result early.
module simon_data_out
    import simon_pkg::*;
#(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              R,
    input  logic              newResult,
    input  logic              enc_dec,
    input  logic [1:0][N-1:0] BLOCK,
    output logic              readyRes,
    output logic [7:0]        txByte,
    output logic              txValid,
    input  logic              txReady,
    output logic              pktDone,
    output logic [7:0]        pktCount,
    output logic              overflow,
    output state_e            dbg_state
);

    localparam int PKT_BYTES = pkt_bytes(N);
    localparam int BLK_BYTES = N / 4;
    localparam int PAD_BYTES = PKT_BYTES - 2 - BLK_BYTES;

    state_e            state, next_state;
    logic              hold_full;
    logic              hold_enc;
    logic [1:0][N-1:0] hold_blk;
    logic              load, shift_en, pkt_last, tx_fire;
    logic              drain, capture;
    byte_t             info;
    byte_t [PKT_BYTES-1:0] pkt_img;
    byte_t             top_byte;

    // Byte link: a byte transfers on a rising clk edge where txValid && txReady;
    // txValid never drops and txByte never changes until that transfer happens.
    assign tx_fire = (state == SEND) && txReady;

    // A drain and a new result on the same edge leave the register full without overflow.
    assign drain   = (state == IDLE) && hold_full;
    assign capture = newResult && (!hold_full || drain);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            hold_full <= 1'b0;
            hold_enc  <= 1'b0;
            hold_blk  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (capture) begin
                hold_full <= 1'b1;
                hold_enc  <= enc_dec;
                hold_blk  <= BLOCK;
            end else if (drain) begin
                hold_full <= 1'b0;
            end
            if (newResult && hold_full && !drain)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        info                 = '0;
        info[INFO_VALID_BIT] = 1'b1;
        info[INFO_ENC_BIT]   = hold_enc;
    end

    assign pkt_img = {info, pktCount, hold_blk, {(PAD_BYTES * 8){1'b0}}};

    always_ff @(posedge clk or posedge R) begin
        if (R) state <= IDLE;
        else   state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        txValid    = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                txValid  = 1'b1;
                shift_en = txReady;
                if (txReady && pkt_last)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            pktDone  <= 1'b0;
            pktCount <= '0;
        end else begin
            pktDone <= tx_fire && pkt_last;
            if (tx_fire && pkt_last)
                pktCount <= pktCount + 8'd1;
        end
    end

    simon_pkt_shift #(
        .PKT_BYTES (PKT_BYTES)
    ) u_shift (
        .clk      (clk),
        .rst      (R),
        .load     (load),
        .load_img (pkt_img),
        .shift_en (shift_en),
        .top_byte (top_byte),
        .last     (pkt_last)
    );

    assign txByte    = top_byte;
    assign readyRes  = !hold_full;
    assign dbg_state = state;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for simon_data_out: vector table plus hand-written multi-cycle sequences.
module tb_simon_data_out;
    import simon_pkg::*;

    localparam int N   = 16;
    localparam int PKT = 10;

    logic              clk = 1'b0;
    logic              R;
    logic              newResult;
    logic              enc_dec;
    logic [1:0][N-1:0] BLOCK;
    logic              readyRes;
    logic [7:0]        txByte;
    logic              txValid;
    logic              txReady = 1'b1;
    logic              pktDone;
    logic [7:0]        pktCount;
    logic              overflow;
    state_e            dbg_state;

    simon_data_out #(.N(N)) dut (
        .clk       (clk),
        .R         (R),
        .newResult (newResult),
        .enc_dec   (enc_dec),
        .BLOCK     (BLOCK),
        .readyRes  (readyRes),
        .txByte    (txByte),
        .txValid   (txValid),
        .txReady   (txReady),
        .pktDone   (pktDone),
        .pktCount  (pktCount),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        enc;
        logic [15:0] b1;
        logic [15:0] b0;
        logic        stall;
        logic [7:0]  exp_info;
    } vec_t;

    vec_t       vecs [4];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_cnt = 8'd0;
    int         done_pulses = 0;
    logic       stall_mode = 1'b0;
    int         idle_run = 0;
    int         last_gap = -1;
    logic       gap_armed = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_byte = 8'd0;
    int         pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Link partner: always ready, or ready on alternate cycles in stall mode.
    always @(posedge clk) begin
        #2;
        txReady = stall_mode ? ~txReady : 1'b1;
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (R) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            idle_run   = 0;
            gap_armed  = 1'b0;
            pos        = 0;
        end else begin
            if (pktDone) done_pulses++;
            if (prev_stall && txValid) check("stall_hold", txByte, prev_byte);
            if (txValid && !prev_valid && gap_armed) begin
                last_gap  = idle_run;
                gap_armed = 1'b0;
            end
            idle_run = txValid ? 0 : idle_run + 1;
            if (txValid && txReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h, expected no transfer", txByte);
                end else begin
                    check("tx_byte", txByte, exp_q.pop_front());
                end
                pos++;
                if (pos == PKT) begin
                    pos       = 0;
                    gap_armed = 1'b1;
                end
            end
            prev_stall = txValid && !txReady;
            prev_byte  = txByte;
            prev_valid = txValid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_pkt(input logic enc, input logic [15:0] b1, input logic [15:0] b0);
        exp_q.push_back({1'b1, enc, 6'b0});
        exp_q.push_back(model_cnt);
        exp_q.push_back(b1[15:8]);
        exp_q.push_back(b1[7:0]);
        exp_q.push_back(b0[15:8]);
        exp_q.push_back(b0[7:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        model_cnt = model_cnt + 8'd1;
    endtask

    task automatic issue(input logic enc, input logic [15:0] b1, input logic [15:0] b0,
                         input bit accepted);
        newResult = 1'b1;
        enc_dec   = enc;
        BLOCK[1]  = b1;
        BLOCK[0]  = b0;
        if (accepted) push_pkt(enc, b1, b0);
        tick();
        newResult = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || txValid || !readyRes) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
        end
        tick(2);
    endtask

    task automatic do_reset();
        R = 1'b1;
        tick(2);
        R = 1'b0;
        exp_q.delete();
        model_cnt = 8'd0;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        R         = 1'b1;
        newResult = 1'b0;
        enc_dec   = 1'b0;
        BLOCK     = '0;

        vecs[0] = '{enc: 1'b0, b1: 16'h6565, b0: 16'h6877, stall: 1'b0, exp_info: 8'h80};
        vecs[1] = '{enc: 1'b1, b1: 16'h6565, b0: 16'h6877, stall: 1'b1, exp_info: 8'hC0};
        vecs[2] = '{enc: 1'b1, b1: 16'h1234, b0: 16'hABCD, stall: 1'b1, exp_info: 8'hC0};
        vecs[3] = '{enc: 1'b0, b1: 16'hFFFF, b0: 16'h0001, stall: 1'b0, exp_info: 8'h80};

        tick(2);
        check("rst_readyRes", readyRes, 1);
        check("rst_txValid", txValid, 0);
        check("rst_txByte", txByte, 0);
        check("rst_pktDone", pktDone, 0);
        check("rst_pktCount", pktCount, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, IDLE);
        R = 1'b0;
        tick();

        // First packet: latency and frame contents.
        done_pulses = 0;
        issue(1'b0, 16'h6565, 16'h6877, 1'b1);
        check("lat_e0_txValid", txValid, 0);
        check("lat_e0_readyRes", readyRes, 0);
        tick();
        check("lat_e1_txValid", txValid, 1);
        check("lat_e1_txByte", txByte, 8'h80);
        check("lat_e1_readyRes", readyRes, 1);
        wait_drain();
        check("p1_done_pulses", done_pulses, 1);
        check("p1_pktCount", pktCount, 1);

        // Vector table: info byte, count byte and stall behaviour.
        for (int i = 0; i < 4; i++) begin
            stall_mode = vecs[i].stall;
            d0 = done_pulses;
            issue(vecs[i].enc, vecs[i].b1, vecs[i].b0, 1'b1);
            tick();
            check("vec_info", txByte, vecs[i].exp_info);
            wait_drain();
            check("vec_done_pulses", done_pulses - d0, 1);
            check("vec_pktCount", pktCount, model_cnt);
        end
        stall_mode = 1'b0;

        // Back-to-back results, then one that must be dropped.
        do_reset();
        check("b2b_overflow0", overflow, 0);
        issue(1'b0, 16'h1111, 16'h2222, 1'b1);
        tick(2);
        issue(1'b1, 16'h3333, 16'h4444, 1'b1);
        check("b2b_readyRes", readyRes, 0);
        check("b2b_overflow1", overflow, 0);
        tick();
        issue(1'b0, 16'hDEAD, 16'hBEEF, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_readyRes", readyRes, 0);
        last_gap = -1;
        wait_drain();
        check("b2b_idle_gap", last_gap, 1);
        check("ovf_sticky", overflow, 1);
        check("b2b_pktCount", pktCount, 2);

        // 256 packets: count byte reaches FF and the counter wraps.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            if (k == 255) check("pre_wrap_count", pktCount, 8'hFF);
            issue(k[0], 16'(k), 16'hA5A5 ^ 16'(k), 1'b1);
            wait_drain();
        end
        check("wrap_pktCount", pktCount, 8'h00);

        // Reset while byte 5 is on the link.
        issue(1'b0, 16'h0F0F, 16'hF0F0, 1'b1);
        wait_drain();
        check("pre_rst_pktCount", pktCount, 1);
        issue(1'b0, 16'h1357, 16'h2468, 1'b1);
        tick(5);
        check("mid_byte5", txByte, 8'h24);
        #1;
        R = 1'b1;
        #1;
        check("mid_rst_txValid", txValid, 0);
        check("mid_rst_pktCount", pktCount, 0);
        check("mid_rst_readyRes", readyRes, 1);
        check("mid_rst_txByte", txByte, 0);
        check("mid_rst_state", dbg_state, IDLE);
        exp_q.delete();
        model_cnt = 8'd0;
        tick(2);
        R = 1'b0;
        tick();
        issue(1'b1, 16'hCAFE, 16'hF00D, 1'b1);
        tick();
        check("restart_info", txByte, 8'hC0);
        wait_drain();
        check("restart_pktCount", pktCount, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
